key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Upstream conditioner for the raw DE2 pushbuttons (KEY[n], active-low, asynchronous, bouncy).
//  Per key, it provides:
//   - a two-flop synchroniser;
//   - a stable-count debouncer;
//   - one-cycle press and release strobes;
//   - optional auto-repeat strobes.
//  Its outputs drive the load/clock enables of the 16-bit switch-capture register and the HEX display stages.
//  Keys are independent; all state is per key.
// PARAMETERS
//  NUM_KEYS        2        number of buttons conditioned
//  DEBOUNCE_CYCLES 1000000  consecutive stable cycles needed to accept a change (20 ms @ 50 MHz); must be >= 1
//  REPEAT_DELAY    25000000 cycles from press strobe to first repeat strobe; 0 disables auto-repeat
//  REPEAT_RATE     5000000  cycles between successive repeat strobes; must be >= 1
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  reset_n      in   1         asynchronous, active-low reset
//  key_n_in     in   NUM_KEYS  raw button pins, 0 = pressed, asynchronous to clk
//  key_level    out  NUM_KEYS  debounced state, 1 = pressed
//  key_press    out  NUM_KEYS  1-cycle strobe, first cycle key_level is 1
//  key_release  out  NUM_KEYS  1-cycle strobe, first cycle key_level is 0
//  key_repeat   out  NUM_KEYS  1-cycle auto-repeat strobe while held
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - sync flops s1, s2 are set to 1 (released);
//   - debounce counter = 0, repeat counter = 0;
//   - key_level, key_press, key_release and key_repeat are all 0.
//  Synchroniser: s1 <= key_n_in, s2 <= s1. raw = ~s2. No other logic touches key_n_in.
//  Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)), evaluated each cycle:
//   - raw == key_level: cnt <= 0;
//   - raw != key_level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1;
//   - raw != key_level and cnt == DEBOUNCE_CYCLES-1: key_level <= raw, cnt <= 0.
//  Latency: a pin change held steady is first captured by s1 at edge 1; key_level changes at edge 2+DEBOUNCE_CYCLES.
//  Any bounce shorter than DEBOUNCE_CYCLES cycles at s2 clears cnt and produces no output change.
//  Strobes (all registered, high exactly 1 cycle):
//   - key_press: on the 0->1 transition of key_level;
//   - key_release: on the 1->0 transition of key_level.
//  Per-key repeat FSM, states IDLE, DELAY, REPEAT:
//   - IDLE: on the key_press cycle, rcnt <= 1. If REPEAT_DELAY > 0, go to DELAY; otherwise stay IDLE.
//   - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY: key_repeat = 1, rcnt <= 1, go to REPEAT.
//   - REPEAT: rcnt increments each cycle. When rcnt == REPEAT_RATE: key_repeat = 1, rcnt <= 1.
//   - Any state, key_level == 0: go to IDLE, rcnt <= 0 (key_release takes priority; no repeat in that cycle).
//   - Consequence: the first repeat comes REPEAT_DELAY cycles after the press strobe, then one every REPEAT_RATE cycles.
//  Strobe exclusivity:
//   - key_press, key_release and key_repeat are never high together for the same key;
//   - strobes on different keys may coincide.
//  Reset mid-operation:
//   - all state clears immediately;
//   - a button still held after reset deasserts is re-detected as a new press at edge 2+DEBOUNCE_CYCLES.
//  Counters saturate-free by construction: each clears before it can wrap. Widths are derived from the parameters.
// TESTING  (bench: NUM_KEYS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
//  1. Reset applied, then released with key_n_in=2'b11
//     -> all outputs 0 for 20 cycles; no strobes.
//  2. key_n_in[0] 1->0, held
//     -> key_level[0] rises at edge 6; key_press[0] high at edge 6 only; key[1] outputs stay 0.
//  3. key_n_in[0] low for 3 cycles, then high (bounce)
//     -> key_level, key_press and key_release stay 0.
//  4. Key 0 held 30 cycles after press strobe at edge 6
//     -> key_repeat[0] at edges 16, 19, 22, 25, 28, 31, 34; never with key_press.
//  5. Key 0 released after case 4
//     -> key_release[0] 1 cycle at release edge 6; key_repeat[0] stops; no further strobes.
//  6. Both keys pressed; reset_n pulsed low mid-hold at edge 8
//     -> outputs 0 immediately; after reset release, key_press=2'b11 at edge 6.

Source files
------------

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchroniser, stable-count debouncer,
// press/release strobes and auto-repeat, one independent lane per key.
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DLY    = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE   = RW'(REPEAT_RATE);
  localparam bit            RPT_ON   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rstate_t;

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_n_in;
      s2 <= s1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic          raw;
    logic          level;
    logic          level_next;
    logic          press;
    logic          rel;
    logic          rep;
    logic          rise;
    logic          fall;
    logic          rep_hit;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    rstate_t       state;
    rstate_t       state_next;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_next;
    logic [RW-1:0] rcnt_inc;

    assign raw = ~s2[k];

    always_comb begin
      cnt_next   = '0;
      level_next = level;
      if (raw != level) begin
        if (cnt == CNT_LAST) level_next = raw;
        else                 cnt_next   = cnt + 1'b1;
      end
    end

    assign rise     = level_next & ~level;
    assign fall     = ~level_next & level;
    assign rcnt_inc = rcnt + 1'b1;

    // Strobe fires on the edge where the counter reaches its target,
    // so the repeat lands exactly DELAY/RATE cycles after its predecessor.
    always_comb begin
      rep_hit = 1'b0;
      unique case (state)
        DELAY:   rep_hit = level_next && (rcnt_inc == R_DLY);
        REPEAT:  rep_hit = level_next && (rcnt_inc == R_RATE);
        default: rep_hit = 1'b0;
      endcase
    end

    always_comb begin
      state_next = state;
      rcnt_next  = rcnt;
      if (!level_next) begin
        state_next = IDLE;
        rcnt_next  = '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              rcnt_next  = '0;
              state_next = RPT_ON ? DELAY : IDLE;
            end
          end
          DELAY: begin
            if (rep_hit) begin
              state_next = REPEAT;
              rcnt_next  = '0;
            end else begin
              rcnt_next = rcnt_inc;
            end
          end
          REPEAT: rcnt_next = rep_hit ? '0 : rcnt_inc;
          default: begin
            state_next = IDLE;
            rcnt_next  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        rep   <= 1'b0;
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        cnt   <= cnt_next;
        level <= level_next;
        press <= rise;
        rel   <= fall;
        rep   <= rep_hit;
        state <= state_next;
        rcnt  <= rcnt_next;
      end
    end

    assign key_level[k]   = level;
    assign key_press[k]   = press;
    assign key_release[k] = rel;
    assign key_repeat[k]  = rep;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner with a
// cycle-level reference model of the debounce/repeat rules.
module tb_key_conditioner;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_n_in = 2'b11;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n_in(key_n_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  // Reference model: pin delayed two edges, level accepted after DB
  // consecutive disagreeing samples, repeats timed from press edge.
  bit [NK-1:0] m_d1 = '1, m_d2 = '1, m_lvl = '0;
  bit [NK-1:0] m_press = '0, m_rel = '0, m_rep = '0;
  int m_run [NK];
  int m_pt  [NK];
  int m_t = 0;

  always @(posedge clk or negedge reset_n) begin : model
    bit raw, l, p, r, q;
    int run, pt, held;
    if (!reset_n) begin
      m_d1 <= '1; m_d2 <= '1; m_lvl <= '0;
      m_press <= '0; m_rel <= '0; m_rep <= '0;
      m_t <= 0;
      for (int k = 0; k < NK; k++) begin
        m_run[k] <= 0;
        m_pt[k]  <= 0;
      end
    end else begin
      m_t  <= m_t + 1;
      m_d1 <= key_n_in;
      m_d2 <= m_d1;
      for (int k = 0; k < NK; k++) begin
        raw = !m_d2[k];
        l = m_lvl[k]; run = m_run[k]; pt = m_pt[k];
        p = 0; r = 0; q = 0;
        if (raw != l) begin
          run++;
          if (run == DB) begin
            l = raw; run = 0;
            if (raw) begin p = 1; pt = m_t + 1; end
            else r = 1;
          end
        end else run = 0;
        if (l && !p && RD > 0) begin
          held = m_t + 1 - pt;
          if (held >= RD && (held - RD) % RR == 0) q = 1;
        end
        m_lvl[k] <= l; m_run[k] <= run; m_pt[k] <= pt;
        m_press[k] <= p; m_rel[k] <= r; m_rep[k] <= q;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got %h want 00",
               {key_level, key_press, key_release, key_repeat});
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
        errors++;
        $display("FAIL idle edge %0d got %h want 00", n,
                 {key_level, key_press, key_release, key_repeat});
      end
    end
  endtask

  task automatic test_press();
    key_n_in[0] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      checks++;
      if (key_level !== ((n >= 6) ? 2'b01 : 2'b00) ||
          key_press !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL press edge %0d got lvl=%b prs=%b want lvl=%b prs=%b",
                 n, key_level, key_press, (n >= 6) ? 2'b01 : 2'b00,
                 (n == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_repeat();
    logic [NK-1:0] exp_rep;
    for (int n = 7; n <= 36; n++) begin
      step();
      exp_rep = (n >= 16 && (n - 16) % 3 == 0) ? 2'b01 : 2'b00;
      checks++;
      if (key_repeat !== exp_rep || key_press !== 2'b00 ||
          key_level !== 2'b01) begin
        errors++;
        $display("FAIL repeat edge %0d got rep=%b prs=%b lvl=%b want rep=%b",
                 n, key_repeat, key_press, key_level, exp_rep);
      end
    end
  endtask

  task automatic test_release();
    key_n_in[0] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      checks++;
      if (key_release !== ((n == 6) ? 2'b01 : 2'b00) ||
          key_level !== ((n < 6) ? 2'b01 : 2'b00) ||
          (n >= 6 && key_repeat !== 2'b00) ||
          key_repeat !== m_rep) begin
        errors++;
        $display("FAIL release edge %0d got rel=%b lvl=%b rep=%b", n,
                 key_release, key_level, key_repeat);
      end
    end
  endtask

  task automatic test_bounce();
    key_n_in[0] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 4) key_n_in[0] = 1'b1;
      step();
      checks++;
      if ({key_level, key_press, key_release} !== 6'b0) begin
        errors++;
        $display("FAIL bounce edge %0d got lvl=%b prs=%b rel=%b want 0",
                 n, key_level, key_press, key_release);
      end
    end
  endtask

  task automatic test_reset_mid();
    key_n_in = 2'b00;
    for (int n = 1; n <= 8; n++) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got %h want 00",
               {key_level, key_press, key_release, key_repeat});
    end
    step();
    reset_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (key_press !== ((n == 6) ? 2'b11 : 2'b00) ||
          key_level !== ((n >= 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL repress edge %0d got prs=%b lvl=%b", n,
                 key_press, key_level);
      end
    end
    key_n_in = 2'b11;
    for (int n = 0; n < 10; n++) step();
  endtask

  task automatic test_random();
    int hold [NK];
    for (int k = 0; k < NK; k++) hold[k] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          key_n_in[k] = ~key_n_in[k];
          hold[k] = ($urandom_range(0, 3) == 0) ?
                    $urandom_range(20, 60) : $urandom_range(1, 8);
        end
      end
      step();
      checks++;
      if (key_level !== m_lvl || key_press !== m_press ||
          key_release !== m_rel || key_repeat !== m_rep) begin
        errors++;
        $display("FAIL random cyc %0d got %b/%b/%b/%b want %b/%b/%b/%b", n,
                 key_level, key_press, key_release, key_repeat,
                 m_lvl, m_press, m_rel, m_rep);
      end
      checks++;
      if (((key_press & key_release) | (key_press & key_repeat) |
           (key_release & key_repeat)) !== 2'b00) begin
        errors++;
        $display("FAIL exclusive cyc %0d prs=%b rel=%b rep=%b", n,
                 key_press, key_release, key_repeat);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    key_n_in = 2'b11;
    repeat (3) @(negedge clk);
    test_reset();
    test_press();
    test_repeat();
    test_release();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
